// File: rtl/pdu_io_port.sv
// pdu_io_port: CPU IO-bus responder for the debug unit.
// CPU stores drive the LEDs and the 8-digit hex display. Operator switch
// input, qualified by a rising edge on the `valid` switch, is latched for
// the CPU along with full/overrun status. A free-running cycle counter is
// also provided.
module pdu_io_port #(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  in,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  output logic [4:0]  out0,
  output logic        ready,
  output logic        ovf,
  output logic [2:0]  an,
  output logic [3:0]  seg
);

  // Word addresses (byte address >> 2)
  localparam logic [5:0] A_LED  = 6'h00;
  localparam logic [5:0] A_DISP = 6'h02;
  localparam logic [5:0] A_STAT = 6'h03;
  localparam logic [5:0] A_DATA = 6'h04;
  localparam logic [5:0] A_CNT  = 6'h05;

  logic [4:0]           out0_q,    out0_d;
  logic [31:0]          disp_q,    disp_d;
  logic [4:0]           in_data_q, in_data_d;
  logic                 in_full_q, in_full_d;
  logic                 ovf_q,     ovf_d;
  logic [31:0]          cnt_q,     cnt_d;
  logic [SCAN_BITS-1:0] scan_q,    scan_d;
  // [0]=s1, [1]=s2, [2]=s3: 2-FF synchronizer followed by an edge-detect delay
  logic [2:0]           vld_pipe_q, vld_pipe_d;

  logic [5:0] waddr;
  logic       rise, pop, full_after_pop;
  logic       wr_led, wr_disp, wr_stat, wr_cnt;

  // Byte-lane bits of the address are not decoded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^io_addr[1:0];

  assign waddr   = io_addr[7:2];
  assign wr_led  = io_we && (waddr == A_LED);
  assign wr_disp = io_we && (waddr == A_DISP);
  assign wr_stat = io_we && (waddr == A_STAT);
  assign wr_cnt  = io_we && (waddr == A_CNT);
  assign pop     = io_rd && (waddr == A_DATA);

  assign rise           = vld_pipe_q[1] & ~vld_pipe_q[2];
  // A pop in the same cycle frees the slot before the new edge is considered.
  assign full_after_pop = in_full_q & ~pop;

  // Next-state logic for every register in the block.
  always_comb begin
    out0_d     = out0_q;
    disp_d     = disp_q;
    in_data_d  = in_data_q;
    in_full_d  = full_after_pop;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q + 32'd1;
    scan_d     = scan_q + 1'b1;
    vld_pipe_d = {vld_pipe_q[1:0], valid};

    if (wr_led)  out0_d = io_dout[4:0];
    if (wr_disp) disp_d = io_dout;
    if (wr_cnt)  cnt_d  = io_dout;
    if (wr_stat && io_dout[1]) ovf_d = 1'b0;

    // A new edge either fills the slot or flags an overrun; set beats clear.
    if (rise) begin
      if (!full_after_pop) begin
        in_data_d = in;
        in_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over all events.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q     <= '0;
      disp_q     <= '0;
      in_data_q  <= '0;
      in_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      scan_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      out0_q     <= out0_d;
      disp_q     <= disp_d;
      in_data_q  <= in_data_d;
      in_full_q  <= in_full_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Zero-latency read mux; unmapped addresses read zero.
  always_comb begin
    io_din = '0;
    case (waddr)
      A_LED:   io_din = {27'b0, out0_q};
      A_DISP:  io_din = disp_q;
      A_STAT:  io_din = {30'b0, ovf_q, in_full_q};
      A_DATA:  io_din = {27'b0, in_data_q};
      A_CNT:   io_din = cnt_q;
      default: io_din = '0;
    endcase
  end

  assign out0  = out0_q;
  assign ready = ~in_full_q;
  assign ovf   = ovf_q;
  assign an    = scan_q[SCAN_BITS-1 -: 3];
  assign seg   = disp_q[{an, 2'b00} +: 4];

endmodule

// File: tb/tb_pdu_io_port.sv
// Testbench for pdu_io_port: directed steps from the test plan followed by
// a randomized phase, all compared against a cycle-level reference model.
module tb_pdu_io_port;
  localparam int SB = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [4:0]  in_sw = '0;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_dout = '0;
  logic        io_we = 1'b0;
  logic        io_rd = 1'b0;
  logic [31:0] io_din;
  logic [4:0]  out0;
  logic        ready, ovf;
  logic [2:0]  an;
  logic [3:0]  seg;

  int checks = 0;
  int errors = 0;

  pdu_io_port #(.SCAN_BITS(SB)) dut (
    .clk(clk), .rst(rst), .valid(valid), .in(in_sw),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
    .io_din(io_din), .out0(out0), .ready(ready), .ovf(ovf),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0]  m_out0, m_data;
  logic [31:0] m_disp, m_cnt;
  logic        m_full, m_ovf;
  int          m_t;        // cycles since reset, modulo one frame
  logic [2:0]  vh;         // valid as sampled at past edges, [0] = most recent

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_din(input logic [7:0] a);
    case (a[7:2])
      6'h00:   return {27'b0, m_out0};
      6'h02:   return m_disp;
      6'h03:   return {30'b0, m_ovf, m_full};
      6'h04:   return {27'b0, m_data};
      6'h05:   return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: update the model from the inputs the DUT is about to
  // sample, then compare every registered output.
  task automatic tick();
    logic rise, pop, fe;
    int w, dig;
    if (rst) begin
      m_out0 = 0; m_disp = 0; m_data = 0; m_full = 0; m_ovf = 0;
      m_cnt = 0; m_t = 0; vh = 0;
    end else begin
      w    = int'(io_addr[7:2]);
      rise = vh[1] & ~vh[2];
      pop  = io_rd && (w == 4);
      fe   = m_full && !pop;
      if (io_we && w == 0) m_out0 = io_dout[4:0];
      if (io_we && w == 2) m_disp = io_dout;
      if (io_we && w == 3 && io_dout[1]) m_ovf = 0;
      m_full = fe;
      if (rise) begin
        if (!fe) begin m_data = in_sw; m_full = 1; end
        else m_ovf = 1;
      end
      m_cnt = (io_we && w == 5) ? io_dout : m_cnt + 32'd1;
      m_t   = (m_t + 1) % (1 << SB);
      vh    = {vh[1:0], valid};
    end
    @(posedge clk); #1;
    dig = (m_t / (1 << (SB - 3))) % 8;
    chk("out0", {27'b0, out0}, {27'b0, m_out0});
    chk("ready", {31'b0, ready}, {31'b0, ~m_full});
    chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    chk("an", {29'b0, an}, dig);
    chk("seg", {28'b0, seg}, (m_disp >> (4 * dig)) & 32'hF);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    io_addr = a; #1;
    chk(tag, io_din, exp);
    chk({tag, "_model"}, io_din, exp_din(a));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_dout = d; io_we = 1; tick(); io_we = 0;
  endtask

  initial begin
    // Reset state
    rst = 1; tick(); tick(); rst = 0;
    rd(8'h00, 0, "rst_led"); rd(8'h08, 0, "rst_disp"); rd(8'h0C, 0, "rst_stat");
    rd(8'h10, 0, "rst_data"); rd(8'h14, 0, "rst_cnt");
    chk("rst_ready", {31'b0, ready}, 1);

    // LED write, read back, unmapped address
    wr(8'h00, 32'hFFFF_FFF5);
    chk("led_out0", {27'b0, out0}, 32'h15);
    rd(8'h00, 32'h15, "led_rd"); rd(8'h20, 0, "unmapped");

    // Handshake: ready falls on the third edge after valid rises
    in_sw = 5'h13; valid = 1;
    tick(); chk("hs_e1", {31'b0, ready}, 1);
    tick(); chk("hs_e2", {31'b0, ready}, 1);
    tick(); chk("hs_e3", {31'b0, ready}, 0);
    rd(8'h0C, 1, "hs_stat");
    io_rd = 1; rd(8'h10, 32'h13, "hs_data"); tick(); io_rd = 0;
    chk("hs_ready", {31'b0, ready}, 1);
    rd(8'h0C, 0, "hs_stat2");
    valid = 0; repeat (3) tick();

    // Overrun
    in_sw = 5'h0A; valid = 1; repeat (3) tick(); valid = 0; repeat (3) tick();
    in_sw = 5'h07; valid = 1; repeat (3) tick();
    rd(8'h10, 32'h0A, "ovr_data"); rd(8'h0C, 3, "ovr_stat");
    chk("ovr_flag", {31'b0, ovf}, 1);
    valid = 0;
    wr(8'h0C, 32'h2);
    rd(8'h0C, 1, "ovr_clr");
    repeat (3) tick();

    // Pop coincident with a rise
    in_sw = 5'h1F; valid = 1; tick(); tick();
    io_addr = 8'h10; io_rd = 1; tick(); io_rd = 0;
    chk("pr_ready", {31'b0, ready}, 0);
    rd(8'h10, 32'h1F, "pr_data"); rd(8'h0C, 1, "pr_stat");
    valid = 0; io_addr = 8'h10; io_rd = 1; tick(); io_rd = 0; repeat (3) tick();

    // Counter load and wrap
    wr(8'h14, 32'hFFFF_FFFE);
    rd(8'h14, 32'hFFFF_FFFE, "cnt0"); tick();
    rd(8'h14, 32'hFFFF_FFFF, "cnt1"); tick();
    rd(8'h14, 32'h0, "cnt2"); tick();
    rd(8'h14, 32'h1, "cnt3");

    // Display scan, then reset mid-frame
    rst = 1; tick(); rst = 0;
    wr(8'h08, 32'h8765_4321);
    for (int k = 1; k < 34; k++) begin
      chk("scan_an", {29'b0, an}, (k / 4) % 8);
      chk("scan_seg", {28'b0, seg}, ((k / 4) % 8) + 1);
      tick();
    end
    rst = 1; tick(); rst = 0;
    chk("mid_rst_an", {29'b0, an}, 0);
    chk("mid_rst_seg", {28'b0, seg}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(6))
        0: io_addr = 8'h00;
        1: io_addr = 8'h08;
        2: io_addr = 8'h0C;
        3, 4: io_addr = 8'h10;
        5: io_addr = 8'h14;
        default: io_addr = 8'($urandom);
      endcase
      io_addr[1:0] = 2'($urandom);
      io_dout = $urandom;
      io_we   = ($urandom_range(3) == 0);
      io_rd   = ($urandom_range(2) == 0);
      in_sw   = 5'($urandom);
      if ($urandom_range(3) == 0) valid = ~valid;
      rst     = ($urandom_range(199) == 0);
      #1;
      chk("rnd_din", io_din, exp_din(io_addr));
      tick();
    end
    rst = 0; io_we = 0; io_rd = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
